enc32to5_arb: RTL and testbench
===============================

Name: enc32to5_arb

Overview:
- Sequential 32-to-5 encoder: the reverse direction of the 5-to-32 select decoders in this lab set.
- Captures active-low request lines into a sticky pending register.
- Grants one pending request at a time as a 5-bit code with valid/ack handshake.
- Clears each request only once it is acknowledged.
- Sits between a bank of 32 active-low select/request lines and a consumer that takes one 5-bit index per transaction.

Parameters:
- ROUND_ROBIN, 0, 0 = fixed priority (lowest index wins); 1 = rotating priority starting after the last granted index.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- En  input  1  capture enable; requests are sampled only when En=1.
- D_n  input  [0:31]  active-low request lines; D_n[i]=0 requests index i.
- ack  input  1  consumer acknowledge of current grant.
- A  output  [4:0]  granted index, registered.
- valid  output  1  A holds a live grant, registered.
- multi  output  1  ≥2 requests were pending when the current grant was made, registered.

Behaviour:
- Reset (async, rst=1):
  - pending=0, A=0, valid=0, multi=0, last=31 (so round-robin starts at index 0), state=IDLE.
  - Reset mid-grant drops the grant immediately; no ack is required.
- Capture: at each rising edge with En=1, pending[i] <= 1 for every i where D_n[i]=0. With En=0, nothing is captured; pending holds and granting continues.
- States IDLE, GRANT.
- IDLE:
  - Decision uses registered pending only, not same-edge captures.
  - If pending≠0: select index s, then A<=s, valid<=1, multi<=(popcount(pending)≥2), last<=s, go to GRANT.
  - Otherwise stay in IDLE with valid=0. A holds its previous value.
- Selection:
  - ROUND_ROBIN=0: s = lowest i with pending[i]=1.
  - ROUND_ROBIN=1: s = first set bit scanning last+1, last+2, … mod 32, wrapping 31→0.
- GRANT:
  - A, valid and multi are held stable until ack=1 at a rising edge.
  - On that edge: pending[A]<=0, valid<=0, go to IDLE.
- Same-edge set/clear on the acked index: if En=1 and D_n[A]=0 on the ack edge, set wins and pending[A] stays 1.
- Ack outside GRANT: ignored.
- Latency:
  - Request present at edge N → pending at N → valid=1 after edge N+1.
  - After ack at edge M, valid=0 for at least the cycle following M; the next grant appears after edge M+1.
  - Maximum throughput is one grant per 2 cycles.
- A persistently held D_n[i]=0 re-pends index i after every ack. Under ROUND_ROBIN=1, other requesters are still served in rotation.
- All requests active (D_n=0) is legal. multi=1 on each grant while ≥2 bits are pending.

Test Plan:
1. Reset check: rst pulse mid-GRANT, asynchronous to clk → A=0, valid=0, multi=0 immediately, with no clk edge needed. After release with D_n all ones: valid stays 0 for 10 cycles.
2. Single request, fixed priority: D_n[13]=0 for one cycle with En=1 → valid=1, A=5'd13, multi=0 two edges later. ack=1 for one cycle → valid=0; no further grant.
3. Fixed priority order: pulse D_n[3], D_n[7], D_n[30] low together, then ack each grant → grants 3, 7, 30 in that order. multi=1, 1, 0. valid=0 exactly one cycle between grants.
4. Round-robin wrap (ROUND_ROBIN=1): pending {2, 20, 31}, first grant 2; then inject request 0 before the second decision → grant order 2, 20, 31, 0. This confirms the 31→0 wrap.
5. Enable gating and set-wins: En=0 with D_n[5]=0 → no grant. Then En=1 with D_n[9] held low, acking each grant → index 9 is re-granted after every ack, with pending[9] never observed clear.
6. Ack robustness: ack=1 while IDLE → no state change. ack held high continuously with 4 pending requests → 4 grants, valid toggling 1,0,1,0…, A stable within each grant cycle.

Source files
------------

// File: rtl/enc32to5_arb.sv
// rtl/enc32to5_arb.sv - sequential 32-to-5 encoder/arbiter with sticky pending requests and valid/ack grant handshake
//
// Purpose:
//   Collects active-low request lines into a sticky pending register and
//   hands them out one at a time as a 5-bit index. A request stays pending
//   until the grant that carries it has been acknowledged by the consumer.
//
// Parameters:
//   ROUND_ROBIN  0 = fixed priority, lowest index wins
//                1 = rotating priority, scan starts just after the last grant
//
// Ports:
//   clk    in   1     clock, all state changes on the rising edge
//   rst    in   1     asynchronous active-high reset
//   En     in   1     capture enable for D_n
//   D_n    in   0:31  active-low request lines, D_n[i]=0 requests index i
//   ack    in   1     consumer acknowledge of the current grant
//   A      out  5     granted index (registered)
//   valid  out  1     A carries a live grant (registered)
//   multi  out  1     two or more requests were pending when A was granted

module enc32to5_arb #(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        En,
  input  logic [0:31] D_n,
  input  logic        ack,
  output logic [4:0]  A,
  output logic        valid,
  output logic        multi
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pending_q, pending_d;
  logic [4:0]  a_q, a_d;
  logic [4:0]  last_q, last_d;
  logic        valid_q, valid_d;
  logic        multi_q, multi_d;

  logic [31:0] capture;
  logic [31:0] clear_mask;
  logic [4:0]  sel_idx;
  logic        many_pending;

  // Lowest set bit of v; returns 0 when v is empty (callers gate on |v).
  function automatic logic [4:0] lowest_set(input logic [31:0] v);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) r = i[4:0];
    end
    return r;
  endfunction

  // First set bit found scanning start, start+1, ... with 5-bit wraparound.
  function automatic logic [4:0] first_from(input logic [31:0] v,
                                            input logic [4:0]  start);
    logic [4:0] r;
    logic [4:0] idx;
    logic       found;
    r     = 5'd0;
    found = 1'b0;
    for (int k = 0; k < 32; k++) begin
      idx = start + k[4:0];
      if (!found && v[idx]) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // D_n is declared [0:31]; index i of the vector is request i regardless
  // of the ascending range, so the mapping is done bit by bit.
  always_comb begin
    capture = '0;
    for (int i = 0; i < 32; i++) begin
      capture[i] = En & ~D_n[i];
    end
  end

  // Round-robin starts one past the last grant; last resets to 31 so the
  // first scan begins at index 0.
  always_comb begin
    if (ROUND_ROBIN) sel_idx = first_from(pending_q, last_q + 5'd1);
    else             sel_idx = lowest_set(pending_q);
  end

  // Clearing the lowest set bit leaves something behind only if >= 2 bits are set.
  assign many_pending = |(pending_q & (pending_q - 32'd1));

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    last_d     = last_q;
    valid_d    = valid_q;
    multi_d    = multi_q;
    clear_mask = '0;

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        // Decision uses the registered pending vector only; requests
        // captured on this same edge are considered next cycle.
        if (|pending_q) begin
          a_d     = sel_idx;
          last_d  = sel_idx;
          valid_d = 1'b1;
          multi_d = many_pending;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (ack) begin
          clear_mask = 32'd1 << a_q;
          valid_d    = 1'b0;
          multi_d    = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    // Capture is ORed after the clear so a request still asserted on the
    // ack edge keeps its pending bit.
    pending_d = (pending_q & ~clear_mask) | capture;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      a_q       <= 5'd0;
      last_q    <= 5'd31;
      valid_q   <= 1'b0;
      multi_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      a_q       <= a_d;
      last_q    <= last_d;
      valid_q   <= valid_d;
      multi_q   <= multi_d;
    end
  end

  assign A     = a_q;
  assign valid = valid_q;
  assign multi = multi_q;

endmodule

// File: tb/tb_enc32to5_arb.sv
// tb/tb_enc32to5_arb.sv - directed self-checking bench for enc32to5_arb (fixed and round-robin instances)

module tb_enc32to5_arb;

  logic        clk;
  logic        rst;

  logic        en0, ack0;
  logic [0:31] dn0;
  logic [4:0]  a0;
  logic        valid0, multi0;

  logic        en1, ack1;
  logic [0:31] dn1;
  logic [4:0]  a1;
  logic        valid1, multi1;

  int checks = 0;
  int errors = 0;

  enc32to5_arb #(.ROUND_ROBIN(1'b0)) dut_fp (
    .clk   (clk),
    .rst   (rst),
    .En    (en0),
    .D_n   (dn0),
    .ack   (ack0),
    .A     (a0),
    .valid (valid0),
    .multi (multi0)
  );

  enc32to5_arb #(.ROUND_ROBIN(1'b1)) dut_rr (
    .clk   (clk),
    .rst   (rst),
    .En    (en1),
    .D_n   (dn1),
    .ack   (ack1),
    .A     (a1),
    .valid (valid1),
    .multi (multi1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [4:0] exp3_a [3];
    logic       exp3_m [3];
    logic [4:0] exp4_a [4];
    logic       exp4_m [4];
    logic [4:0] exp6_a [4];
    logic       exp6_m [4];

    exp3_a = '{5'd3, 5'd7, 5'd30};
    exp3_m = '{1'b1, 1'b1, 1'b0};
    exp4_a = '{5'd2, 5'd20, 5'd31, 5'd0};
    exp4_m = '{1'b1, 1'b1, 1'b1, 1'b0};
    exp6_a = '{5'd1, 5'd4, 5'd8, 5'd25};
    exp6_m = '{1'b1, 1'b1, 1'b1, 1'b0};

    rst  = 1'b0;
    en0  = 1'b0; ack0 = 1'b0; dn0 = '1;
    en1  = 1'b0; ack1 = 1'b0; dn1 = '1;
    #1 rst = 1'b1;
    #1;
    chk("reset_valid", {31'd0, valid0}, 32'd0);
    chk("reset_a", {27'd0, a0}, 32'd0);
    chk("reset_multi", {31'd0, multi0}, 32'd0);
    cyc(1);
    rst = 1'b0;

    // 1: async reset in the middle of a grant
    en0 = 1'b1; dn0[4] = 1'b0;
    cyc(1);
    dn0 = '1;
    cyc(1);
    chk("t1_pre_valid", {31'd0, valid0}, 32'd1);
    chk("t1_pre_a", {27'd0, a0}, 32'd4);
    #2 rst = 1'b1;
    #1;
    chk("t1_rst_valid", {31'd0, valid0}, 32'd0);
    chk("t1_rst_a", {27'd0, a0}, 32'd0);
    chk("t1_rst_multi", {31'd0, multi0}, 32'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("t1_idle_after_rst", {31'd0, valid0}, 32'd0);
    end

    // 2: single request, fixed priority
    dn0[13] = 1'b0;
    cyc(1);
    dn0 = '1;
    chk("t2_not_yet", {31'd0, valid0}, 32'd0);
    cyc(1);
    chk("t2_valid", {31'd0, valid0}, 32'd1);
    chk("t2_a", {27'd0, a0}, 32'd13);
    chk("t2_multi", {31'd0, multi0}, 32'd0);
    ack0 = 1'b1;
    cyc(1);
    ack0 = 1'b0;
    chk("t2_ack_drop", {31'd0, valid0}, 32'd0);
    cyc(3);
    chk("t2_no_regrant", {31'd0, valid0}, 32'd0);

    // 3: fixed-priority order 3, 7, 30
    dn0[3] = 1'b0; dn0[7] = 1'b0; dn0[30] = 1'b0;
    cyc(1);
    dn0 = '1;
    cyc(1);
    for (int g = 0; g < 3; g++) begin
      chk("t3_valid", {31'd0, valid0}, 32'd1);
      chk("t3_a", {27'd0, a0}, {27'd0, exp3_a[g]});
      chk("t3_multi", {31'd0, multi0}, {31'd0, exp3_m[g]});
      ack0 = 1'b1;
      cyc(1);
      ack0 = 1'b0;
      chk("t3_gap", {31'd0, valid0}, 32'd0);
      cyc(1);
    end
    chk("t3_done", {31'd0, valid0}, 32'd0);

    // 4: round-robin wrap 2, 20, 31, 0
    en1 = 1'b1;
    dn1[2] = 1'b0; dn1[20] = 1'b0; dn1[31] = 1'b0;
    cyc(1);
    dn1 = '1;
    cyc(1);
    for (int g = 0; g < 4; g++) begin
      chk("t4_valid", {31'd0, valid1}, 32'd1);
      chk("t4_a", {27'd0, a1}, {27'd0, exp4_a[g]});
      chk("t4_multi", {31'd0, multi1}, {31'd0, exp4_m[g]});
      ack1 = 1'b1;
      if (g == 0) dn1[0] = 1'b0;
      cyc(1);
      ack1 = 1'b0;
      dn1 = '1;
      chk("t4_gap", {31'd0, valid1}, 32'd0);
      cyc(1);
    end
    chk("t4_done", {31'd0, valid1}, 32'd0);

    // 5: enable gating, then set-wins on a held request
    en0 = 1'b0; dn0[5] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("t5_gated", {31'd0, valid0}, 32'd0);
    end
    dn0 = '1;
    cyc(2);
    chk("t5_gated_after", {31'd0, valid0}, 32'd0);
    en0 = 1'b1; dn0[9] = 1'b0;
    cyc(2);
    for (int g = 0; g < 3; g++) begin
      chk("t5_valid", {31'd0, valid0}, 32'd1);
      chk("t5_a", {27'd0, a0}, 32'd9);
      chk("t5_multi", {31'd0, multi0}, 32'd0);
      ack0 = 1'b1;
      cyc(1);
      ack0 = 1'b0;
      chk("t5_gap", {31'd0, valid0}, 32'd0);
      cyc(1);
    end
    dn0 = '1;
    chk("t5_last_valid", {31'd0, valid0}, 32'd1);
    ack0 = 1'b1;
    cyc(1);
    ack0 = 1'b0;
    cyc(2);
    chk("t5_released", {31'd0, valid0}, 32'd0);

    // 6: ack while idle, then ack held high through four grants
    ack0 = 1'b1;
    cyc(2);
    chk("t6_idle_ack_valid", {31'd0, valid0}, 32'd0);
    chk("t6_idle_ack_a", {27'd0, a0}, 32'd9);
    dn0[1] = 1'b0; dn0[4] = 1'b0; dn0[8] = 1'b0; dn0[25] = 1'b0;
    cyc(1);
    dn0 = '1;
    for (int c = 0; c < 8; c++) begin
      cyc(1);
      if (c % 2 == 0) begin
        chk("t6_valid_hi", {31'd0, valid0}, 32'd1);
        chk("t6_multi", {31'd0, multi0}, {31'd0, exp6_m[c / 2]});
      end else begin
        chk("t6_valid_lo", {31'd0, valid0}, 32'd0);
      end
      chk("t6_a", {27'd0, a0}, {27'd0, exp6_a[c / 2]});
    end
    cyc(2);
    chk("t6_done", {31'd0, valid0}, 32'd0);
    ack0 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
